// File: rtl/demux1to4_tdm.sv
// Time-division 1-to-4 demultiplexer: collects 4-slot serial frames (slot 0 marked
// by in_sof) and publishes all four lanes together once per complete frame.
module demux1to4_tdm #(
  parameter int WIDTH = 1,
  parameter int ERR_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  input  logic             in_sof,
  output logic [WIDTH-1:0] out0,
  output logic [WIDTH-1:0] out1,
  output logic [WIDTH-1:0] out2,
  output logic [WIDTH-1:0] out3,
  output logic             frame_valid,
  output logic             frame_err,
  output logic [ERR_W-1:0] err_cnt,
  output logic [1:0]       slot
);

  typedef enum logic {IDLE, COLLECT} state_t;

  state_t           state;
  logic [WIDTH-1:0] shadow0;
  logic [WIDTH-1:0] shadow1;
  logic [WIDTH-1:0] shadow2;

  // Slot 3 is never shadowed: it goes straight to out3 on the publishing edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      slot        <= 2'd0;
      shadow0     <= '0;
      shadow1     <= '0;
      shadow2     <= '0;
      out0        <= '0;
      out1        <= '0;
      out2        <= '0;
      out3        <= '0;
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;
      err_cnt     <= '0;
    end else begin
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;
      if (in_valid) begin
        case (state)
          IDLE: begin
            if (in_sof) begin
              shadow0 <= in_data;
              slot    <= 2'd1;
              state   <= COLLECT;
            end
          end
          COLLECT: begin
            if (in_sof) begin
              // Premature SOF restarts the frame with this sample as slot 0.
              frame_err <= 1'b1;
              if (err_cnt != {ERR_W{1'b1}}) begin
                err_cnt <= err_cnt + 1'b1;
              end
              shadow0 <= in_data;
              slot    <= 2'd1;
            end else if (slot == 2'd3) begin
              out0        <= shadow0;
              out1        <= shadow1;
              out2        <= shadow2;
              out3        <= in_data;
              frame_valid <= 1'b1;
              slot        <= 2'd0;
              state       <= IDLE;
            end else begin
              if (slot == 2'd1) begin
                shadow1 <= in_data;
              end else begin
                shadow2 <= in_data;
              end
              slot <= slot + 2'd1;
            end
          end
          default: begin
            state <= IDLE;
            slot  <= 2'd0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_demux1to4_tdm.sv
// Randomized and directed bench for demux1to4_tdm with a frame-level reference model
// feeding a scoreboard queue that a separate monitor drains on every output event.
module tb_demux1to4_tdm;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] in_data = 8'h00;
  logic       in_valid = 1'b0;
  logic       in_sof = 1'b0;
  logic [7:0] out0, out1, out2, out3;
  logic       frame_valid, frame_err;
  logic [3:0] err_cnt;
  logic [1:0] slot;

  demux1to4_tdm #(.WIDTH(8), .ERR_W(4)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_sof(in_sof),
    .out0(out0), .out1(out1), .out2(out2), .out3(out3),
    .frame_valid(frame_valid), .frame_err(frame_err), .err_cnt(err_cnt), .slot(slot)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        is_err;
    logic [31:0] lanes;
    logic [3:0]  errs;
  } ev_t;

  ev_t         exp_q[$];
  logic [7:0]  pend[$];
  logic [31:0] pub_lanes = '0;
  int          model_err = 0;
  int          checks = 0;
  int          fails = 0;

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Frame-level model: a frame is an SOF sample followed by three non-SOF samples.
  task automatic apply_stimulus(input bit v, input bit s, input logic [7:0] d);
    ev_t ev;
    in_valid = v;
    in_sof   = s;
    in_data  = d;
    if (v) begin
      if (s) begin
        if (pend.size() != 0) begin
          model_err = (model_err < 15) ? model_err + 1 : 15;
          ev.is_err = 1'b1;
          ev.lanes  = pub_lanes;
          ev.errs   = 4'(model_err);
          exp_q.push_back(ev);
        end
        pend.delete();
        pend.push_back(d);
      end else if (pend.size() != 0) begin
        pend.push_back(d);
        if (pend.size() == 4) begin
          pub_lanes = {pend[0], pend[1], pend[2], pend[3]};
          ev.is_err = 1'b0;
          ev.lanes  = pub_lanes;
          ev.errs   = 4'(model_err);
          exp_q.push_back(ev);
          pend.delete();
        end
      end
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_sof   = 1'b0;
    check_output("slot", 64'(slot), 64'(pend.size()));
  endtask

  task automatic send_frame(input logic [31:0] f, input int gap);
    for (int i = 0; i < 4; i++) begin
      apply_stimulus(1'b1, i == 0, f[31-8*i -: 8]);
      for (int g = 0; g < gap; g++) apply_stimulus(1'b0, 1'b0, 8'h00);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    check_output("reset_lanes", 64'({out0, out1, out2, out3}), 64'h0);
    check_output("reset_flags", 64'({frame_valid, frame_err, err_cnt, slot}), 64'h0);
    pend.delete();
    exp_q.delete();
    pub_lanes = '0;
    model_err = 0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Monitor: pops one expectation per output pulse, otherwise checks outputs hold.
  initial begin
    logic [31:0] cur_lanes;
    logic [3:0]  cur_errs;
    ev_t         ev;
    cur_lanes = '0;
    cur_errs  = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        cur_lanes = '0;
        cur_errs  = '0;
      end else if (frame_valid || frame_err) begin
        if (exp_q.size() == 0) begin
          check_output("unexpected_pulse", 64'({frame_valid, frame_err}), 64'h0);
        end else begin
          ev = exp_q.pop_front();
          check_output("frame_valid", 64'(frame_valid), 64'(!ev.is_err));
          check_output("frame_err", 64'(frame_err), 64'(ev.is_err));
          check_output("lanes", 64'({out0, out1, out2, out3}), 64'(ev.lanes));
          check_output("err_cnt", 64'(err_cnt), 64'(ev.errs));
          cur_lanes = ev.lanes;
          cur_errs  = ev.errs;
        end
      end else begin
        check_output("hold_lanes", 64'({out0, out1, out2, out3}), 64'(cur_lanes));
        check_output("hold_err_cnt", 64'(err_cnt), 64'(cur_errs));
      end
    end
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check_output("reset_lanes", 64'({out0, out1, out2, out3}), 64'h0);
    check_output("reset_flags", 64'({frame_valid, frame_err, err_cnt, slot}), 64'h0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    send_frame(32'hA1B2C3D4, 0);
    send_frame(32'hA1B2C3D4, 3);
    apply_stimulus(1'b1, 1'b1, 8'h11);
    apply_stimulus(1'b1, 1'b0, 8'h22);
    send_frame(32'h33445566, 0);
    apply_stimulus(1'b1, 1'b0, 8'h77);
    apply_stimulus(1'b1, 1'b0, 8'h88);
    apply_stimulus(1'b1, 1'b0, 8'h99);
    send_frame(32'h5A6B7C8D, 0);
    send_frame(32'h01020304, 0);

    for (int i = 0; i < 400; i++) begin
      apply_stimulus($urandom_range(0, 3) != 0,
                     $urandom_range(0, (pend.size() == 0) ? 1 : 5) == 0,
                     8'($urandom));
    end
    repeat (4) apply_stimulus(1'b0, 1'b0, 8'h00);

    apply_stimulus(1'b1, 1'b1, 8'hE1);
    apply_stimulus(1'b1, 1'b0, 8'hE2);
    do_reset();
    send_frame(32'h01020304, 0);
    apply_stimulus(1'b1, 1'b1, 8'hF0);
    for (int i = 0; i < 17; i++) apply_stimulus(1'b1, 1'b1, 8'(8'hF1 + i));
    repeat (3) apply_stimulus(1'b0, 1'b0, 8'h00);
    check_output("err_cnt_saturated", 64'(err_cnt), 64'd15);
    check_output("scoreboard_drained", 64'(exp_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/demux1to4_tdm.md
Name: demux1to4_tdm

Overview:
- Time-division 1-to-4 demultiplexer: the receive-side counterpart of the mux4to1 select path.
- A single serial sample stream carries 4-slot frames. Slot 0 is marked by a start-of-frame flag.
- The block steers each accepted sample to lane 0..3 by an internal rotating slot counter, replacing external s1/s0 selects.
- It publishes all four lanes together, registered, once per complete frame, and flags malformed frames.

Parameters:
- WIDTH, 1, bit width of each sample and each output lane.
- ERR_W, 4, width of the saturating frame-error counter.

Ports:
- clk  input  1  rising-edge clock; only clock domain.
- rst  input  1  asynchronous, active-high reset.
- in_data  input  WIDTH  serial sample.
- in_valid  input  1  in_data valid this cycle; a sample is accepted only when high.
- in_sof  input  1  start of frame; qualified by in_valid; marks slot 0.
- out0  output  WIDTH  lane 0 (slot 0) of last complete frame, registered.
- out1  output  WIDTH  lane 1, registered.
- out2  output  WIDTH  lane 2, registered.
- out3  output  WIDTH  lane 3, registered.
- frame_valid  output  1  one-cycle pulse: out0..out3 updated this cycle.
- frame_err  output  1  one-cycle pulse: partial frame discarded.
- err_cnt  output  ERR_W  saturating count of frame_err events.
- slot  output  2  next expected slot index {s1,s0}; debug/visibility.

Behaviour:
- Reset (async, rst=1): state=IDLE, slot=0, shadow lanes 0..2=0, out0..out3=0, frame_valid=0, frame_err=0, err_cnt=0.
- Every output is a flop. There is no combinational path from inputs to outputs.
- Cycles with in_valid=0 change nothing. in_sof is ignored when in_valid=0.
- IDLE (slot=0):
  - in_valid & in_sof: shadow0<=in_data, slot<=1, go to COLLECT.
  - in_valid & !in_sof: sample dropped silently, no error, stay in IDLE.
- COLLECT (slot=1..3):
  - in_valid & !in_sof & slot<3: shadow[slot]<=in_data, slot<=slot+1.
  - in_valid & !in_sof & slot==3: on the same edge, out0..out2<=shadow0..2, out3<=in_data, frame_valid<=1, slot<=0, go to IDLE.
  - in_valid & in_sof (premature SOF): frame_err<=1, err_cnt<=err_cnt+1 (saturates at 2^ERR_W-1), shadow0<=in_data, slot<=1, stay in COLLECT.
  - On premature SOF the new SOF sample is kept as slot 0 of the new frame. out0..out3 are unchanged.
- Latency: frame_valid and new lane values appear in the cycle after the edge that accepts the slot-3 sample. Lanes update atomically.
- out0..out3 hold their values until the next complete frame. frame_valid and frame_err are high for exactly one cycle per event.
- Back-to-back frames: an SOF in the cycle right after a slot-3 accept is legal (state is IDLE) and is not an error. A sustained rate of 1 frame per 4 valid cycles is supported.
- Gaps (in_valid=0) mid-frame are allowed and of unbounded length. There is no timeout.
- Reset mid-frame: the partial frame is lost, all outputs clear immediately (async), and the first post-reset frame needs an SOF.
- frame_valid and frame_err are never high in the same cycle. slot always reflects the registered counter.

Test Plan:
- WIDTH=8, after reset: check out0..3=0x00, frame_valid=0, err_cnt=0, slot=0.
- Valid beats 0xA1(sof),0xB2,0xC3,0xD4 on consecutive cycles -> next cycle out0..3=A1,B2,C3,D4, frame_valid=1 for 1 cycle, slot=0.
- Same frame with in_valid=0 for 3 cycles between each beat -> identical outputs; frame_valid only after the 0xD4 accept.
- 0x11(sof),0x22, then 0x33(sof),0x44,0x55,0x66 -> frame_err pulse on the 0x33 beat, err_cnt=1; outputs become 33,44,55,66; out0..3 unchanged before that.
- Three beats 0x77,0x88,0x99 without SOF in IDLE -> dropped; no frame_valid, no frame_err, slot stays 0.
- Assert rst after 2 beats of a frame -> outputs 0 asynchronously; a following full frame 01,02,03,04 -> outputs 01..04. Then 17 forced premature SOFs -> err_cnt saturates at 15.
